// File: rtl/pckt_ingress_framer_pkg.sv
// Shared types for the ingress framer: beat record, FSM states, terminator beat.
package pckt_ingress_pkg;

  // Bytes per beat; the framer IWIDTH parameter must equal this value.
  localparam int unsigned IWIDTH_DEF = 8;

  typedef struct packed {
    logic [IWIDTH_DEF-1:0][7:0] data;
    logic                       sop;
    logic                       eop;
    logic [IWIDTH_DEF-1:0]      empty;
    logic                       error;
  } beat_t;

  typedef enum logic [1:0] {
    IDLE,
    PKT,
    TERM,
    DROP
  } state_t;

  // Synthetic closing beat for a packet whose EOP never arrived.
  localparam beat_t TERM_BEAT = '{data: '0, sop: 1'b0, eop: 1'b1, empty: '1, error: 1'b1};

  // A beat is in error if the link flagged it, or if it marks bytes empty
  // anywhere other than on the last beat of a packet.
  function automatic logic beat_err(beat_t b);
    return b.error | ((|b.empty) & ~b.eop);
  endfunction

endpackage

// File: rtl/pckt_skid_buf.sv
// Two-entry beat buffer with valid/ready. When empty, the incoming beat is
// presented directly as the head so an accepted beat can be consumed in the
// same cycle.
module pckt_skid_buf
  import pckt_ingress_pkg::*;
(
  input  logic  clk,
  input  logic  rstb,
  input  logic  s_valid,
  output logic  s_ready,
  input  beat_t s_beat,
  output logic  h_valid,
  output beat_t h_beat,
  input  logic  pop
);

  beat_t      mem [2];
  logic       rd_ptr;
  logic [1:0] count;
  logic       en_q;
  logic       push;
  logic       bypass;
  logic       store;
  logic       pop_st;
  logic       wr_ptr;

  assign s_ready = en_q & (count != 2'd2);
  assign push    = s_valid & s_ready;
  assign bypass  = pop & (count == 2'd0);
  assign store   = push & ~bypass;
  assign pop_st  = pop & (count != 2'd0);
  assign wr_ptr  = rd_ptr ^ count[0];

  // Head selection: stored entry if any, otherwise the beat being pushed.
  always_comb begin
    h_valid = 1'b1;
    h_beat  = mem[rd_ptr];
    if (count == 2'd0) begin
      h_valid = push;
      h_beat  = s_beat;
    end
  end

  // Occupancy, read pointer and post-reset ready enable.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      en_q   <= 1'b0;
      count  <= '0;
      rd_ptr <= 1'b0;
    end else begin
      en_q   <= 1'b1;
      count  <= count + {1'b0, store} - {1'b0, pop_st};
      rd_ptr <= rd_ptr ^ pop_st;
    end
  end

  // Beat storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= s_beat;
  end

endmodule

// File: rtl/pckt_ingress_framer.sv
// Ingress framer in front of pckt_decoder_top: enforces SOP/EOP framing and a
// maximum packet length, and feeds the decoder without ever presenting a beat
// while the decoder is full.
// Optional statistics counters are built when PCKT_INGRESS_STATS_EN is defined.
module pckt_ingress_framer
  import pckt_ingress_pkg::*;
#(
  parameter int unsigned IWIDTH   = IWIDTH_DEF,
  parameter int unsigned MAXBEATS = 32,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                s_sop,
  input  logic                s_eop,
  input  logic [IWIDTH*8-1:0] s_data,
  input  logic [IWIDTH-1:0]   s_empty,
  input  logic                s_error,
  output logic                in_valid,
  output logic                in_sop,
  output logic                in_eop,
  output logic [IWIDTH*8-1:0] in_data,
  output logic [IWIDTH-1:0]   in_empty,
  output logic                in_error,
  input  logic                ready_out_b,
  output logic [CNT_W-1:0]    stat_pkt,
  output logic [CNT_W-1:0]    stat_drop,
  output logic [CNT_W-1:0]    stat_err
);

  localparam int unsigned BCW = $clog2(MAXBEATS + 1);

  beat_t          s_beat;
  beat_t          head;
  beat_t          nxt;
  beat_t          out_q;
  logic           h_valid;
  logic           pop;
  logic           load;
  logic           load_ok;
  logic           out_vld_q;
  logic           drop_inc;
  logic           hd_err;
  state_t         state_q, state_d;
  logic [BCW-1:0] cnt_q, cnt_d;
  logic           err_q, err_d;

  // Pack the link inputs into a beat record.
  always_comb begin
    s_beat.data  = s_data;
    s_beat.sop   = s_sop;
    s_beat.eop   = s_eop;
    s_beat.empty = s_empty;
    s_beat.error = s_error;
  end

  pckt_skid_buf u_skid (
    .clk     (clk),
    .rstb    (rstb),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_beat  (s_beat),
    .h_valid (h_valid),
    .h_beat  (head),
    .pop     (pop)
  );

  assign in_valid = out_vld_q & ~ready_out_b;
  assign load_ok  = ~out_vld_q | in_valid;
  assign hd_err   = beat_err(head);

  assign in_sop   = out_q.sop;
  assign in_eop   = out_q.eop;
  assign in_data  = out_q.data;
  assign in_empty = out_q.empty;
  assign in_error = out_q.error;

  // Framing FSM: next state, pop/load decisions and the beat to forward.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    pop       = 1'b0;
    load      = 1'b0;
    drop_inc  = 1'b0;
    nxt       = head;
    nxt.empty = head.eop ? head.empty : '0;
    nxt.error = err_q | hd_err;
    if (load_ok) begin
      case (state_q)
        IDLE: begin
          if (h_valid) begin
            pop = 1'b1;
            if (head.sop) begin
              load    = 1'b1;
              cnt_d   = BCW'(1);
              err_d   = hd_err;
              state_d = head.eop ? IDLE : PKT;
            end else begin
              drop_inc = 1'b1;
            end
          end
        end
        PKT: begin
          if (h_valid) begin
            if (head.sop) begin
              state_d = TERM;
            end else if (head.eop) begin
              pop     = 1'b1;
              load    = 1'b1;
              state_d = IDLE;
            end else if (cnt_q == BCW'(MAXBEATS - 1)) begin
              pop       = 1'b1;
              load      = 1'b1;
              nxt.eop   = 1'b1;
              nxt.error = 1'b1;
              state_d   = DROP;
            end else begin
              pop   = 1'b1;
              load  = 1'b1;
              cnt_d = cnt_q + BCW'(1);
              err_d = err_q | hd_err;
            end
          end
        end
        TERM: begin
          load    = 1'b1;
          nxt     = TERM_BEAT;
          state_d = IDLE;
        end
        DROP: begin
          if (h_valid) begin
            if (head.sop) begin
              state_d = IDLE;
            end else begin
              pop      = 1'b1;
              drop_inc = 1'b1;
              if (head.eop) state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Per-packet context is cleared on every entry to IDLE.
    if (state_d == IDLE) begin
      cnt_d = '0;
      err_d = 1'b0;
    end
  end

  // FSM state, beat counter and sticky packet error.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Output register: loads when empty or when its beat is being taken.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else if (load) begin
      out_vld_q <= 1'b1;
      out_q     <= nxt;
    end else if (in_valid) begin
      out_vld_q <= 1'b0;
    end
  end

`ifdef PCKT_INGRESS_STATS_EN
  logic [CNT_W-1:0] pkt_cnt, drop_cnt, errb_cnt;

  // Saturating statistics, counted on actual decoder transfers and drops.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
      errb_cnt <= '0;
    end else begin
      if (in_valid & in_eop & ~&pkt_cnt)    pkt_cnt  <= pkt_cnt + CNT_W'(1);
      if (drop_inc & ~&drop_cnt)            drop_cnt <= drop_cnt + CNT_W'(1);
      if (in_valid & in_error & ~&errb_cnt) errb_cnt <= errb_cnt + CNT_W'(1);
    end
  end

  assign stat_pkt  = pkt_cnt;
  assign stat_drop = drop_cnt;
  assign stat_err  = errb_cnt;
`else
  logic unused_stats;
  assign unused_stats = drop_inc;
  assign stat_pkt     = '0;
  assign stat_drop    = '0;
  assign stat_err     = '0;
`endif

endmodule

// File: tb/tb_pckt_ingress_framer.sv
// Directed self-checking bench for pckt_ingress_framer.
module tb_pckt_ingress_framer;

`ifdef PCKT_INGRESS_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rstb = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_sop = 1'b0;
  logic        s_eop = 1'b0;
  logic [63:0] s_data = '0;
  logic [7:0]  s_empty = '0;
  logic        s_error = 1'b0;
  logic        in_valid;
  logic        in_sop;
  logic        in_eop;
  logic [63:0] in_data;
  logic [7:0]  in_empty;
  logic        in_error;
  logic        ready_out_b = 1'b0;
  logic [15:0] stat_pkt;
  logic [15:0] stat_drop;
  logic [15:0] stat_err;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // packed as {sop, eop, err, empty[7:0], data[63:0]}
  typedef struct {
    logic [74:0] v;
    int          cyc;
  } obs_t;
  obs_t q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (in_valid === 1'b1) q.push_back('{v: {in_sop, in_eop, in_error, in_empty, in_data}, cyc: cyc});
  end

  pckt_ingress_framer #(.IWIDTH(8), .MAXBEATS(32), .CNT_W(16)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_sop       (s_sop),
    .s_eop       (s_eop),
    .s_data      (s_data),
    .s_empty     (s_empty),
    .s_error     (s_error),
    .in_valid    (in_valid),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_data     (in_data),
    .in_empty    (in_empty),
    .in_error    (in_error),
    .ready_out_b (ready_out_b),
    .stat_pkt    (stat_pkt),
    .stat_drop   (stat_drop),
    .stat_err    (stat_err)
  );

  function automatic logic [63:0] dpat(input int k);
    return 64'(k) * 64'h0101010101010101;
  endfunction

  task automatic push_beat(input logic sop, input logic eop, input logic [63:0] d,
                           input logic [7:0] emp, input logic err, output int acc);
    int n;
    n = 0;
    s_valid = 1'b1; s_sop = sop; s_eop = eop; s_data = d; s_empty = emp; s_error = err;
    @(negedge clk);
    while (s_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (s_ready !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL push_timeout: s_ready=%b required 1", s_ready);
    end
    @(posedge clk);
    #1;
    acc = cyc;
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_empty = '0; s_error = 1'b0;
  endtask

  task automatic apply_reset();
    s_valid = 1'b0;
    ready_out_b = 1'b0;
    @(negedge clk);
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    q.delete();
    rstb = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstb = 1'b0;
    #1;
    tests_run++;
    if ({in_valid, in_sop, in_eop, in_error} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: {valid,sop,eop,err}=%b required 0000", {in_valid, in_sop, in_eop, in_error});
    end
    tests_run++;
    if ({in_data, in_empty} !== 72'h0) begin
      tests_failed++;
      $display("FAIL reset_data: data=%h empty=%h required 0", in_data, in_empty);
    end
    tests_run++;
    if (s_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_s_ready_low: got %b required 0", s_ready);
    end
    tests_run++;
    if ({stat_pkt, stat_drop, stat_err} !== 48'h0) begin
      tests_failed++;
      $display("FAIL reset_stats: %h %h %h required 0", stat_pkt, stat_drop, stat_err);
    end
    @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (s_ready !== 1'b1 || in_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: s_ready=%b in_valid=%b required 1,0", s_ready, in_valid);
    end
  endtask

  task automatic test_basic();
    logic [74:0] ex[4];
    int a0, a;
    apply_reset();
    push_beat(1'b1, 1'b0, dpat(1), 8'h00, 1'b0, a0);
    push_beat(1'b0, 1'b0, dpat(2), 8'h00, 1'b0, a);
    push_beat(1'b0, 1'b0, dpat(3), 8'h00, 1'b0, a);
    push_beat(1'b0, 1'b1, dpat(4), 8'hF0, 1'b0, a);
    repeat (4) @(negedge clk);
    ex[0] = {3'b100, 8'h00, dpat(1)};
    ex[1] = {3'b000, 8'h00, dpat(2)};
    ex[2] = {3'b000, 8'h00, dpat(3)};
    ex[3] = {3'b010, 8'hF0, dpat(4)};
    tests_run++;
    if (q.size() != 4) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d beats required 4", q.size());
    end
    tests_run++;
    if (q.size() < 4 || q[0].cyc != a0 || q[3].cyc != a0 + 3) begin
      tests_failed++;
      $display("FAIL basic_latency: first out cycle %0d required %0d, span must be 3", q.size() > 0 ? q[0].cyc : -1, a0);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= q.size() || q[i].v !== ex[i]) begin
        tests_failed++;
        $display("FAIL basic_beat%0d: got %h required %h", i, i < q.size() ? q[i].v : 75'h0, ex[i]);
      end
    end
    tests_run++;
    if (stat_pkt !== 16'(STATS)) begin
      tests_failed++;
      $display("FAIL basic_stat_pkt: got %0d required %0d", stat_pkt, STATS);
    end
  endtask

  task automatic test_backpressure();
    int bad, n;
    logic sr;
    apply_reset();
    bad = 0;
    n = 0;
    sr = 1'b1;
    fork
      begin
        int a;
        for (int i = 0; i < 6; i++) push_beat(i == 0, i == 5, dpat(16 + i), 8'h00, 1'b0, a);
      end
      begin
        while (q.size() < 2 && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        if (q.size() < 2) begin
          tests_run++; tests_failed++;
          $display("FAIL bp_start_timeout: got %0d beats required 2", q.size());
        end
        ready_out_b = 1'b1;
        repeat (5) begin
          @(negedge clk);
          if (in_valid !== 1'b0) bad++;
        end
        sr = s_ready;
        @(posedge clk);
        #1;
        ready_out_b = 1'b0;
      end
    join
    repeat (6) @(negedge clk);
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL bp_in_valid_gated: in_valid high in %0d stalled cycles required 0", bad);
    end
    tests_run++;
    if (sr !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_s_ready_full: got %b required 0", sr);
    end
    tests_run++;
    if (q.size() != 6) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d beats required 6", q.size());
    end
    for (int i = 0; i < 6; i++) begin
      logic [74:0] e;
      e = {i == 0, i == 5, 1'b0, 8'h00, dpat(16 + i)};
      tests_run++;
      if (i >= q.size() || q[i].v !== e) begin
        tests_failed++;
        $display("FAIL bp_beat%0d: got %h required %h", i, i < q.size() ? q[i].v : 75'h0, e);
      end
    end
  endtask

  task automatic test_missing_eop();
    logic [74:0] ex[5];
    int a;
    apply_reset();
    push_beat(1'b1, 1'b0, dpat(5), 8'h00, 1'b0, a);
    push_beat(1'b0, 1'b0, dpat(6), 8'h00, 1'b0, a);
    push_beat(1'b1, 1'b0, dpat(7), 8'h00, 1'b0, a);
    push_beat(1'b0, 1'b1, dpat(8), 8'h00, 1'b0, a);
    repeat (6) @(negedge clk);
    ex[0] = {3'b100, 8'h00, dpat(5)};
    ex[1] = {3'b000, 8'h00, dpat(6)};
    ex[2] = {3'b011, 8'hFF, 64'h0};
    ex[3] = {3'b100, 8'h00, dpat(7)};
    ex[4] = {3'b010, 8'h00, dpat(8)};
    tests_run++;
    if (q.size() != 5) begin
      tests_failed++;
      $display("FAIL term_count: got %0d beats required 5", q.size());
    end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (i >= q.size() || q[i].v !== ex[i]) begin
        tests_failed++;
        $display("FAIL term_beat%0d: got %h required %h", i, i < q.size() ? q[i].v : 75'h0, ex[i]);
      end
    end
    tests_run++;
    if (stat_err !== 16'(STATS) || stat_pkt !== 16'(2 * STATS)) begin
      tests_failed++;
      $display("FAIL term_stats: err=%0d pkt=%0d required %0d %0d", stat_err, stat_pkt, STATS, 2 * STATS);
    end
  endtask

  task automatic test_maxbeats();
    logic [74:0] e31, e30;
    int a;
    apply_reset();
    for (int i = 1; i <= 40; i++) push_beat(i == 1, i == 40, dpat(i), 8'h00, 1'b0, a);
    repeat (4) @(negedge clk);
    e30 = {3'b000, 8'h00, dpat(31)};
    e31 = {3'b011, 8'h00, dpat(32)};
    tests_run++;
    if (q.size() != 32) begin
      tests_failed++;
      $display("FAIL max_count: got %0d beats required 32", q.size());
    end
    tests_run++;
    if (q.size() < 31 || q[30].v !== e30) begin
      tests_failed++;
      $display("FAIL max_beat31: got %h required %h", q.size() > 30 ? q[30].v : 75'h0, e30);
    end
    tests_run++;
    if (q.size() < 32 || q[31].v !== e31) begin
      tests_failed++;
      $display("FAIL max_beat32: got %h required %h", q.size() > 31 ? q[31].v : 75'h0, e31);
    end
    tests_run++;
    if (stat_drop !== 16'(8 * STATS) || stat_err !== 16'(STATS) || stat_pkt !== 16'(STATS)) begin
      tests_failed++;
      $display("FAIL max_stats: drop=%0d err=%0d pkt=%0d required %0d %0d %0d",
               stat_drop, stat_err, stat_pkt, 8 * STATS, STATS, STATS);
    end
  endtask

  task automatic test_idle_drop();
    logic [74:0] e;
    int a;
    apply_reset();
    push_beat(1'b0, 1'b0, dpat(8'hA1), 8'h00, 1'b0, a);
    push_beat(1'b0, 1'b1, dpat(8'hA2), 8'h00, 1'b0, a);
    push_beat(1'b1, 1'b1, dpat(8'hA3), 8'h0F, 1'b0, a);
    repeat (4) @(negedge clk);
    e = {3'b110, 8'h0F, dpat(8'hA3)};
    tests_run++;
    if (q.size() != 1 || q[0].v !== e) begin
      tests_failed++;
      $display("FAIL idle_drop_beat: got %0d beats, first %h required 1 beat %h", q.size(), q.size() > 0 ? q[0].v : 75'h0, e);
    end
    tests_run++;
    if (stat_drop !== 16'(2 * STATS) || stat_pkt !== 16'(STATS)) begin
      tests_failed++;
      $display("FAIL idle_drop_stats: drop=%0d pkt=%0d required %0d %0d", stat_drop, stat_pkt, 2 * STATS, STATS);
    end
  endtask

  task automatic test_error_sticky();
    logic [74:0] ex[4];
    int a;
    apply_reset();
    push_beat(1'b1, 1'b0, dpat(9), 8'h0F, 1'b0, a);
    push_beat(1'b0, 1'b0, dpat(10), 8'h00, 1'b0, a);
    push_beat(1'b0, 1'b1, dpat(11), 8'h80, 1'b0, a);
    push_beat(1'b1, 1'b1, dpat(12), 8'h00, 1'b0, a);
    repeat (4) @(negedge clk);
    ex[0] = {3'b101, 8'h00, dpat(9)};
    ex[1] = {3'b001, 8'h00, dpat(10)};
    ex[2] = {3'b011, 8'h80, dpat(11)};
    ex[3] = {3'b110, 8'h00, dpat(12)};
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= q.size() || q[i].v !== ex[i]) begin
        tests_failed++;
        $display("FAIL err_beat%0d: got %h required %h", i, i < q.size() ? q[i].v : 75'h0, ex[i]);
      end
    end
    tests_run++;
    if (stat_err !== 16'(3 * STATS)) begin
      tests_failed++;
      $display("FAIL err_stat: got %0d required %0d", stat_err, 3 * STATS);
    end
  endtask

  task automatic test_reset_midpkt();
    logic [74:0] e;
    int a;
    apply_reset();
    ready_out_b = 1'b1;
    push_beat(1'b1, 1'b0, dpat(13), 8'h00, 1'b0, a);
    push_beat(1'b0, 1'b0, dpat(14), 8'h00, 1'b0, a);
    push_beat(1'b0, 1'b0, dpat(15), 8'h00, 1'b0, a);
    tests_run++;
    if (s_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_full: s_ready=%b required 0", s_ready);
    end
    q.delete();
    rstb = 1'b0;
    ready_out_b = 1'b0;
    @(negedge clk);
    tests_run++;
    if (in_valid !== 1'b0 || s_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: in_valid=%b s_ready=%b required 0,0", in_valid, s_ready);
    end
    @(negedge clk);
    rstb = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (q.size() != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_no_term: got %0d beats required 0", q.size());
    end
    push_beat(1'b0, 1'b0, dpat(16), 8'h00, 1'b0, a);
    push_beat(1'b1, 1'b1, dpat(17), 8'h00, 1'b0, a);
    repeat (4) @(negedge clk);
    e = {3'b110, 8'h00, dpat(17)};
    tests_run++;
    if (q.size() != 1 || q[0].v !== e) begin
      tests_failed++;
      $display("FAIL rst_mid_next_pkt: got %0d beats, first %h required 1 beat %h", q.size(), q.size() > 0 ? q[0].v : 75'h0, e);
    end
    tests_run++;
    if (stat_drop !== 16'(STATS)) begin
      tests_failed++;
      $display("FAIL rst_mid_drop: got %0d required %0d", stat_drop, STATS);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_missing_eop();
    test_maxbeats();
    test_idle_drop();
    test_error_sticky();
    test_reset_midpkt();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
